// File: rtl/fetch_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fetch_seq_pkg                                       |
// | Description : Shared CPU constants for the instruction fetch      |
// |               sequencer: FSM state encodings and counter width.   |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
package fetch_seq_pkg;

  // Fetch FSM states; the encodings are fixed and shared across the CPU.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  // Wait counter width: large enough for the maximum timeout of 255.
  localparam int unsigned CNT_W = 8;

endpackage : fetch_seq_pkg
`default_nettype wire

// File: rtl/fetch_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fetch_seq_if                                        |
// | Description : Control, memory and instruction-register signals    |
// |               of the fetch sequencer.                             |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
interface fetch_seq_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          run;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rdy;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] instr;
  logic          instr_vld;
  logic          instr_ack;
  logic [AW-1:0] pc;
  logic          err;

  // The fetch sequencer itself.
  modport master (
    input  run, br_taken, br_target, mem_rdy, mem_data, instr_ack,
    output mem_req, mem_addr, instr, instr_vld, pc, err
  );

  // Memory / control / downstream side.
  modport slave (
    output run, br_taken, br_target, mem_rdy, mem_data, instr_ack,
    input  mem_req, mem_addr, instr, instr_vld, pc, err
  );
endinterface : fetch_seq_if
`default_nettype wire

// File: rtl/fetch_seq_pc_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : pc_reg                                              |
// | Description : Program counter with load (redirect), increment     |
// |               modulo 2^AW and synchronous active-low clear.       |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module pc_reg #(
  parameter int AW = 8
) (
  input  wire logic          clk_i,
  input  wire logic          clr_ni,
  input  wire logic          load_i,
  input  wire logic [AW-1:0] load_val_i,
  input  wire logic          inc_i,
  output logic      [AW-1:0] pc_o
);

  localparam logic [AW-1:0] C_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  // Next PC: a redirect wins over the increment; the add wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + C_ONE;
    end
  end

  // PC register, updated on the falling clock edge.
  always_ff @(negedge clk_i) begin
    if (!clr_ni) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : pc_reg
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fetch_seq                                           |
// | Description : Instruction fetch sequencer. Issues one memory read |
// |               at a time, captures the returned instruction, holds |
// |               it until acknowledged, handles branches and a       |
// |               sticky fetch timeout.                               |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int TMO = 15
) (
  input  wire logic   clk_i,
  input  wire logic   clr_ni,
  fetch_seq_if.master bus
);

  localparam logic [CNT_W-1:0] C_TMO     = CNT_W'(TMO);
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DW-1:0]     instr_q, instr_d;
  logic              vld_q, vld_d;
  logic              req_q, req_d;
  logic              err_q, err_d;
  logic              br_eff;
  logic              pc_load;
  logic              pc_inc;
  logic [AW-1:0]     pc;

  pc_reg #(
    .AW (AW)
  ) u_pc_reg (
    .clk_i      (clk_i),
    .clr_ni     (clr_ni),
    .load_i     (pc_load),
    .load_val_i (bus.br_target),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  // Next-state, wait counter, instruction register and PC control.
  // A branch outranks data/timeout, which outranks the downstream ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + C_CNT_ONE;
    instr_d = instr_q;
    vld_d   = vld_q;
    err_d   = err_q;
    pc_inc  = 1'b0;
    // After a timeout the block is frozen in IDLE, so branches are dropped.
    br_eff  = bus.br_taken & ~err_q;
    pc_load = br_eff;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.run && !err_q) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (br_eff) begin
          // Data from the abandoned request is dropped; refetch at target.
          cnt_d   = '0;
          state_d = ST_REQ;
        end else if (bus.mem_rdy) begin
          instr_d = bus.mem_data;
          vld_d   = 1'b1;
          pc_inc  = 1'b1;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else if (cnt_inc == C_TMO) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (br_eff) begin
          vld_d   = 1'b0;
          state_d = ST_REQ;
        end else if (bus.instr_ack) begin
          vld_d   = 1'b0;
          state_d = bus.run ? ST_REQ : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The request strobe is registered and is high exactly while in REQ.
    req_d = (state_d == ST_REQ);
  end

  // Sequencer state registers, updated on the falling clock edge.
  always_ff @(negedge clk_i) begin
    if (!clr_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      vld_q   <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = pc;
  assign bus.pc        = pc;
  assign bus.instr     = instr_q;
  assign bus.instr_vld = vld_q;
  assign bus.err       = err_q;

endmodule : fetch_seq
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_fetch_seq                                        |
// | Description : Self-checking bench for fetch_seq: transaction-     |
// |               level reference model plus directed scenarios.      |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module tb_fetch_seq;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic clk;
  logic clr_n;
  int   total;
  int   bad;
  bit   chk_en;

  fetch_seq_if #(.AW(AW), .DW(DW)) bus ();

  fetch_seq #(
    .AW  (AW),
    .DW  (DW),
    .TMO (TMO)
  ) u_dut (
    .clk_i  (clk),
    .clr_ni (clr_n),
    .bus    (bus)
  );

  // Clock: state changes on the falling edge (5, 15, ...).
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Reference model, in terms of a fetch in flight / instruction held.
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_instr;
  logic          m_vld;
  logic          m_err;
  logic          m_req;
  logic          m_inflight;
  int            m_cnt;

  initial begin
    m_pc = '0; m_instr = '0; m_vld = 1'b0; m_err = 1'b0;
    m_req = 1'b0; m_inflight = 1'b0; m_cnt = 0;
  end

  always @(negedge clk) begin
    if (!clr_n) begin
      m_pc = '0; m_instr = '0; m_vld = 1'b0; m_err = 1'b0;
      m_req = 1'b0; m_inflight = 1'b0; m_cnt = 0;
    end else if (!m_err) begin
      if (bus.br_taken) m_pc = bus.br_target;
      if (m_req) begin
        m_req      = 1'b0;
        m_inflight = 1'b1;
        m_cnt      = 0;
      end else if (m_inflight) begin
        if (bus.br_taken) begin
          m_inflight = 1'b0;
          m_req      = 1'b1;
        end else if (bus.mem_rdy) begin
          m_instr    = bus.mem_data;
          m_vld      = 1'b1;
          m_pc       = m_pc + 8'd1;
          m_inflight = 1'b0;
        end else begin
          m_cnt = m_cnt + 1;
          if (m_cnt == TMO) begin
            m_err      = 1'b1;
            m_inflight = 1'b0;
          end
        end
      end else if (m_vld) begin
        if (bus.br_taken) begin
          m_vld = 1'b0;
          m_req = 1'b1;
        end else if (bus.instr_ack) begin
          m_vld = 1'b0;
          m_req = bus.run;
        end
      end else begin
        m_req = bus.run;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, mid-way between active edges.
  always @(posedge clk) begin
    if (chk_en) begin
      check("mdl mem_req",   32'(bus.mem_req),   32'(m_req));
      check("mdl mem_addr",  32'(bus.mem_addr),  32'(m_pc));
      check("mdl pc",        32'(bus.pc),        32'(m_pc));
      check("mdl instr",     32'(bus.instr),     32'(m_instr));
      check("mdl instr_vld", 32'(bus.instr_vld), 32'(m_vld));
      check("mdl err",       32'(bus.err),       32'(m_err));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (bus.mem_req !== 1'b1 && k < 20) begin
      step(1);
      k++;
    end
    check("wait_req timeout", 32'(bus.mem_req), 32'd1);
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 1'b0;
    clr_n = 1'b0;
    bus.run = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.mem_rdy = 1'b0; bus.mem_data = '0; bus.instr_ack = 1'b0;
    step(3);
    chk_en = 1'b1;
    check("rst mem_req", 32'(bus.mem_req), 32'd0);
    check("rst pc",      32'(bus.pc),      32'd0);
    check("rst instr",   32'(bus.instr),   32'd0);
    check("rst vld",     32'(bus.instr_vld), 32'd0);
    check("rst err",     32'(bus.err),     32'd0);

    // Basic fetch: data two cycles after the request.
    clr_n = 1'b1; bus.run = 1'b1;
    wait_req();
    check("s1 addr0", 32'(bus.mem_addr), 32'h00);
    step(1);
    step(1);
    bus.mem_rdy = 1'b1; bus.mem_data = 16'hA5C3;
    step(1);
    bus.mem_rdy = 1'b0;
    check("s1 instr", 32'(bus.instr), 32'hA5C3);
    check("s1 vld",   32'(bus.instr_vld), 32'd1);
    check("s1 pc",    32'(bus.pc), 32'h01);
    bus.instr_ack = 1'b1;
    step(1);
    bus.instr_ack = 1'b0;
    check("s1 req2",  32'(bus.mem_req), 32'd1);
    check("s1 addr1", 32'(bus.mem_addr), 32'h01);

    // PC wrap: branch to FF from HOLD, then fetch.
    step(1);
    bus.mem_rdy = 1'b1; bus.mem_data = 16'h1111;
    step(1);
    bus.mem_rdy = 1'b0;
    check("s2 pc2", 32'(bus.pc), 32'h02);
    bus.br_taken = 1'b1; bus.br_target = 8'hFF;
    step(1);
    bus.br_taken = 1'b0;
    check("s2 vld clr", 32'(bus.instr_vld), 32'd0);
    check("s2 addrFF",  32'(bus.mem_addr), 32'hFF);
    step(1);
    bus.mem_rdy = 1'b1; bus.mem_data = 16'h2222;
    step(1);
    bus.mem_rdy = 1'b0;
    check("s2 wrap pc", 32'(bus.pc), 32'h00);

    // Branch in the same cycle as MEM_RDY discards the data.
    bus.instr_ack = 1'b1;
    step(1);
    bus.instr_ack = 1'b0;
    step(1);
    bus.mem_rdy = 1'b1; bus.mem_data = 16'hBEEF;
    bus.br_taken = 1'b1; bus.br_target = 8'h40;
    step(1);
    bus.mem_rdy = 1'b0; bus.br_taken = 1'b0;
    check("s3 vld", 32'(bus.instr_vld), 32'd0);
    check("s3 req", 32'(bus.mem_req), 32'd1);
    check("s3 addr40", 32'(bus.mem_addr), 32'h40);
    check("s3 instr kept", 32'(bus.instr), 32'h2222);

    // HOLD without ack for 5 cycles, then RUN=0 and ack -> IDLE.
    step(1);
    bus.mem_rdy = 1'b1; bus.mem_data = 16'h1234;
    step(1);
    bus.mem_rdy = 1'b0;
    step(5);
    check("s4 instr stable", 32'(bus.instr), 32'h1234);
    check("s4 vld stable",   32'(bus.instr_vld), 32'd1);
    bus.run = 1'b0; bus.instr_ack = 1'b1;
    step(1);
    bus.instr_ack = 1'b0;
    step(3);
    check("s4 idle req", 32'(bus.mem_req), 32'd0);
    check("s4 pc41", 32'(bus.pc), 32'h41);

    // Timeout: 15 WAIT cycles without data.
    bus.run = 1'b1;
    wait_req();
    step(15);
    check("s5 err early", 32'(bus.err), 32'd0);
    step(1);
    check("s5 err set", 32'(bus.err), 32'd1);
    bus.br_taken = 1'b1; bus.br_target = 8'h77;
    step(1);
    bus.br_taken = 1'b0;
    step(5);
    check("s5 no req", 32'(bus.mem_req), 32'd0);
    check("s5 pc held", 32'(bus.pc), 32'h41);
    clr_n = 1'b0;
    step(1);
    check("s5 err clr", 32'(bus.err), 32'd0);

    // Reset during WAIT, then a late MEM_RDY is ignored.
    clr_n = 1'b1;
    wait_req();
    step(2);
    clr_n = 1'b0;
    step(1);
    clr_n = 1'b1; bus.run = 1'b0;
    bus.mem_rdy = 1'b1; bus.mem_data = 16'hFFFF;
    step(1);
    bus.mem_rdy = 1'b0;
    check("s6 instr", 32'(bus.instr), 32'd0);
    check("s6 vld",   32'(bus.instr_vld), 32'd0);
    check("s6 req",   32'(bus.mem_req), 32'd0);
    check("s6 pc",    32'(bus.pc), 32'd0);
    step(2);
    check("s6 vld later", 32'(bus.instr_vld), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_seq
`default_nettype wire
